// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan controller.
package seg_pkg;

    // Each digit dwell is divided into this many brightness slots
    localparam int unsigned SLOT_CNT = 16;

    // Active-high pattern for a dark digit
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Active-high hex glyphs, bit0 = a ... bit6 = g, bit7 (dp) left clear
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host-side control and display-side drive bundle of seg_scan_ctrl.
interface seg_scan_ctrl_if #(
    parameter int unsigned NUM_DIG = 8
);
    logic                   en;
    logic                   load;
    logic [4*NUM_DIG-1:0]   data;
    logic [NUM_DIG-1:0]     dp;
    logic [NUM_DIG-1:0]     blink_mask;
    logic                   blank_lz;
    logic [3:0]             bright;
    logic [NUM_DIG-1:0]     sel;
    logic [7:0]             seg;
    logic                   frame_done;

    // Host / testbench side
    modport master (
        output en, load, data, dp, blink_mask, blank_lz, bright,
        input  sel, seg, frame_done
    );

    // Controller side
    modport slave (
        input  en, load, data, dp, blink_mask, blank_lz, bright,
        output sel, seg, frame_done
    );

endinterface

// File: rtl/seg_decode.sv
// Combinational hex nibble to active-high segment pattern with decimal point.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output logic [7:0] o_seg_c
);

    // Table lookup, dp merged into bit 7
    assign o_seg_c = SEG_TABLE[i_nibble] | {i_dp, 7'b000_0000};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with tear-free double buffering,
// PWM brightness, per-digit blink and leading-zero blanking.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned SCAN_FREQ      = 1000,
    parameter int unsigned NUM_DIG        = 8,
    parameter int unsigned BLINK_HZ       = 2,
    parameter int unsigned SEL_ACTIVE_LOW = 0,
    parameter int unsigned SEG_ACTIVE_LOW = 1
) (
    input  logic            clk,
    input  logic            reset,
    seg_scan_ctrl_if.slave  bus
);

    localparam int unsigned DWELL      = CLK_FREQ / SCAN_FREQ;
    localparam int unsigned SLOT_LEN   = DWELL / SLOT_CNT;
    localparam int unsigned BLINK_HALF = CLK_FREQ / (2 * BLINK_HZ);
    localparam int unsigned IDX_W      = $clog2(NUM_DIG);
    localparam int unsigned SUB_W      = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int unsigned BLK_W      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned DATA_W     = 4 * NUM_DIG;

    localparam logic [NUM_DIG-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? {NUM_DIG{1'b1}} : {NUM_DIG{1'b0}};
    localparam logic [7:0]         SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    // Reject configurations the slot/blink counters cannot represent
    if ((DWELL % SLOT_CNT) != 0 || DWELL < SLOT_CNT || BLINK_HALF < 1 ||
        NUM_DIG < 2 || NUM_DIG > 16) begin : g_bad_cfg
        $error("seg_scan_ctrl: unsupported parameter combination");
    end

    // Scan position: tick_cnt is {r_slot, r_sub} in units of SLOT_LEN
    logic [SUB_W-1:0]   r_sub;
    logic [3:0]         r_slot;
    logic [IDX_W-1:0]   r_idx;
    logic [BLK_W-1:0]   r_blk_cnt;
    logic               r_blk_ph;

    // Shadow (host-written) and active (displayed) buffers
    logic [DATA_W-1:0]  r_sh_data;
    logic [NUM_DIG-1:0] r_sh_dp;
    logic [NUM_DIG-1:0] r_sh_mask;
    logic [DATA_W-1:0]  r_act_data;
    logic [NUM_DIG-1:0] r_act_dp;
    logic [NUM_DIG-1:0] r_act_mask;

    logic               r_frame_done;
    logic [NUM_DIG-1:0] r_sel;
    logic [7:0]         r_seg;

    logic               w_sub_wrap;
    logic               w_tick_wrap;
    logic               w_last_dig;
    logic               w_boundary;
    logic               w_blk_wrap;
    logic [3:0]         w_nib;
    logic               w_dig_dp;
    logic [IDX_W-1:0]   w_msnz;
    logic               w_lit;
    logic [7:0]         w_seg_dec;
    logic [NUM_DIG-1:0] w_onehot;

    assign w_sub_wrap  = (r_sub == SUB_W'(SLOT_LEN - 1));
    assign w_tick_wrap = w_sub_wrap && (r_slot == 4'(SLOT_CNT - 1));
    assign w_last_dig  = (r_idx == IDX_W'(NUM_DIG - 1));
    assign w_boundary  = bus.en && w_tick_wrap && w_last_dig;
    assign w_blk_wrap  = (r_blk_cnt == BLK_W'(BLINK_HALF - 1));

    // Dwell, digit and blink-phase counters; all parked at zero while disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sub     <= '0;
            r_slot    <= '0;
            r_idx     <= '0;
            r_blk_cnt <= '0;
            r_blk_ph  <= 1'b0;
        end else if (!bus.en) begin
            r_sub     <= '0;
            r_slot    <= '0;
            r_idx     <= '0;
            r_blk_cnt <= '0;
            r_blk_ph  <= 1'b0;
        end else begin
            r_sub <= w_sub_wrap ? '0 : r_sub + SUB_W'(1);
            if (w_sub_wrap) begin
                r_slot <= r_slot + 4'd1;
            end
            if (w_tick_wrap) begin
                r_idx <= w_last_dig ? '0 : r_idx + IDX_W'(1);
            end
            r_blk_cnt <= w_blk_wrap ? '0 : r_blk_cnt + BLK_W'(1);
            if (w_blk_wrap) begin
                r_blk_ph <= ~r_blk_ph;
            end
        end
    end

    // Double buffer: commit only on a frame boundary (or at once when idle);
    // a load landing on the boundary itself bypasses the shadow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_data  <= '0;
            r_sh_dp    <= '0;
            r_sh_mask  <= '0;
            r_act_data <= '0;
            r_act_dp   <= '0;
            r_act_mask <= '0;
        end else begin
            if (bus.load) begin
                r_sh_data <= bus.data;
                r_sh_dp   <= bus.dp;
                r_sh_mask <= bus.blink_mask;
            end
            if (bus.load && (!bus.en || w_boundary)) begin
                r_act_data <= bus.data;
                r_act_dp   <= bus.dp;
                r_act_mask <= bus.blink_mask;
            end else if (w_boundary) begin
                r_act_data <= r_sh_data;
                r_act_dp   <= r_sh_dp;
                r_act_mask <= r_sh_mask;
            end
        end
    end

    // One-cycle pulse following each frame boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_boundary;
        end
    end

    // Current digit contents and the blanking decision
    always_comb begin
        w_nib    = r_act_data[{r_idx, 2'b00} +: 4];
        w_dig_dp = r_act_dp[r_idx];
        w_msnz   = '0;
        for (int unsigned k = 0; k < NUM_DIG; k++) begin
            if (r_act_data[k*4 +: 4] != 4'h0) begin
                w_msnz = IDX_W'(k);
            end
        end
        w_lit = 1'b1;
        if (r_blk_ph && r_act_mask[r_idx]) begin
            w_lit = 1'b0;
        end
        // idx > msnz already excludes digit 0
        if (bus.blank_lz && (r_idx > w_msnz) && !w_dig_dp) begin
            w_lit = 1'b0;
        end
        w_onehot = NUM_DIG'(1) << r_idx;
    end

    seg_decode u_decode (
        .i_nibble (w_nib),
        .i_dp     (w_dig_dp),
        .o_seg_c  (w_seg_dec)
    );

    // Registered drive; sel gated by brightness slot, seg held for the dwell
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel <= SEL_OFF;
            r_seg <= SEG_OFF ^ SEG_BLANK;
        end else if (!bus.en || !w_lit) begin
            r_sel <= SEL_OFF;
            r_seg <= SEG_OFF ^ SEG_BLANK;
        end else begin
            r_sel <= SEL_OFF ^ ((r_slot <= bus.bright) ? w_onehot : {NUM_DIG{1'b0}});
            r_seg <= SEG_OFF ^ w_seg_dec;
        end
    end

    assign bus.sel        = r_sel;
    assign bus.seg        = r_seg;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (DWELL = 16, blink half-period 16).
module tb_seg_scan_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pos      = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.NUM_DIG(8)) bus ();

    seg_scan_ctrl #(
        .CLK_FREQ       (3200),
        .SCAN_FREQ      (200),
        .NUM_DIG        (8),
        .BLINK_HZ       (100),
        .SEL_ACTIVE_LOW (0),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_dig(input string tag, input logic [7:0] esel, input logic [7:0] eseg);
        check({tag, "_sel"}, 32'(bus.sel), 32'(esel));
        check({tag, "_seg"}, 32'(bus.seg), 32'(eseg));
    endtask

    task automatic tick();
        @(negedge clk);
        pos++;
    endtask

    // Align to the negedge where frame_done is high: DUT state is idx 0, tick 0
    task automatic sync();
        int b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (bus.frame_done !== 1'b1 && b < 400);
        if (bus.frame_done !== 1'b1) check("frame_sync", 32'(bus.frame_done), 32'd1);
        pos = 0;
    endtask

    task automatic goto(input int p);
        while (pos < p) tick();
    endtask

    // Registered output of digit k, slot s appears k*16+s+1 edges after sync
    task automatic view(input int k, input int s);
        goto(k * 16 + s + 1);
    endtask

    task automatic load_vec(input logic [31:0] d, input logic [7:0] p, input logic [7:0] m);
        bus.data       = d;
        bus.dp         = p;
        bus.blink_mask = m;
        bus.load       = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset          = 1'b1;
        bus.en         = 1'b0;
        bus.load       = 1'b0;
        bus.data       = '0;
        bus.dp         = '0;
        bus.blink_mask = '0;
        bus.blank_lz   = 1'b0;
        bus.bright     = 4'd15;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state, still before any commit
        chk_dig("rst", 8'h00, 8'hFF);

        // Basic decode after first commit
        bus.en = 1'b1;
        load_vec(32'h0000_1234, 8'h00, 8'h00);
        sync();
        view(0, 0); chk_dig("d0_4", 8'h01, 8'h99);
        view(1, 0); chk_dig("d1_3", 8'h02, 8'hB0);
        view(3, 0); chk_dig("d3_1", 8'h08, 8'hF9);
        view(4, 0); chk_dig("d4_0", 8'h10, 8'hC0);

        // Leading-zero blanking
        bus.blank_lz = 1'b1;
        sync();
        view(3, 0); chk_dig("lz_d3", 8'h08, 8'hF9);
        view(4, 0); chk_dig("lz_d4", 8'h00, 8'hFF);
        view(7, 0); chk_dig("lz_d7", 8'h00, 8'hFF);
        load_vec(32'h0000_1234, 8'h40, 8'h00);
        sync();
        view(5, 0); chk_dig("lzdp_d5", 8'h00, 8'hFF);
        view(6, 0); chk_dig("lzdp_d6", 8'h40, 8'h40);
        view(7, 0); chk_dig("lzdp_d7", 8'h00, 8'hFF);

        // Mid-frame load must not tear the frame
        bus.blank_lz = 1'b0;
        load_vec(32'h0000_1234, 8'h00, 8'h00);
        sync();
        goto(3 * 16 + 5);
        load_vec(32'h1111_1111, 8'h00, 8'h00);
        view(4, 0); chk_dig("tear_d4", 8'h10, 8'hC0);
        view(7, 0); chk_dig("tear_d7", 8'h80, 8'hC0);
        goto(127); check("fd_before", 32'(bus.frame_done), 32'd0);
        goto(128); check("fd_pulse", 32'(bus.frame_done), 32'd1);
        goto(129); check("fd_after", 32'(bus.frame_done), 32'd0);
        chk_dig("new_d0", 8'h01, 8'hF9);
        goto(128 + 5 * 16 + 1); chk_dig("new_d5", 8'h20, 8'hF9);

        // Brightness duty over one dwell of digit 2
        bus.bright = 4'd3;
        sync();
        cnt = 0;
        for (int p = 2 * 16 + 1; p <= 2 * 16 + 16; p++) begin
            goto(p);
            if (bus.sel !== 8'h00) cnt++;
        end
        check("bright3_duty", 32'(cnt), 32'd4);
        bus.bright = 4'd0;
        sync();
        cnt = 0;
        for (int p = 2 * 16 + 1; p <= 2 * 16 + 16; p++) begin
            goto(p);
            if (bus.sel !== 8'h00) cnt++;
        end
        check("bright0_duty", 32'(cnt), 32'd1);
        bus.bright = 4'd15;

        // Blink: phase flips every dwell, so digit 0 sees phase 0, digit 1 phase 1
        load_vec(32'h1111_1111, 8'h00, 8'h01);
        sync();
        view(0, 0); chk_dig("blk01_d0", 8'h01, 8'hF9);
        view(0, 8); chk_dig("blk01_d0s8", 8'h01, 8'hF9);
        view(1, 0); chk_dig("blk01_d1", 8'h02, 8'hF9);
        load_vec(32'h1111_1111, 8'h00, 8'hFF);
        sync();
        view(0, 0); chk_dig("blkff_d0", 8'h01, 8'hF9);
        view(1, 0); chk_dig("blkff_d1", 8'h00, 8'hFF);
        view(2, 0); chk_dig("blkff_d2", 8'h04, 8'hF9);
        view(3, 0); chk_dig("blkff_d3", 8'h00, 8'hFF);

        // Disabled: dark outputs, load commits immediately
        bus.en = 1'b0;
        tick(); tick();
        chk_dig("dis", 8'h00, 8'hFF);
        load_vec(32'h0000_0007, 8'h00, 8'h00);
        tick();
        chk_dig("dis_load", 8'h00, 8'hFF);
        bus.en = 1'b1;
        tick();
        chk_dig("en_d0_7", 8'h01, 8'hF8);

        // Reset mid-frame with a pending shadow load
        sync();
        goto(5 * 16 + 3);
        load_vec(32'h8888_8888, 8'hFF, 8'h00);
        goto(5 * 16 + 6);
        #2 reset = 1'b1;
        #1 chk_dig("async_rst", 8'h00, 8'hFF);
        @(negedge clk);
        reset = 1'b0;
        pos = 0;
        view(0, 0); chk_dig("rel_d0", 8'h01, 8'hC0);
        view(1, 0); chk_dig("rel_d1", 8'h02, 8'hC0);
        sync();
        view(0, 0); chk_dig("rel_next_d0", 8'h01, 8'hC0);
        view(7, 0); chk_dig("rel_next_d7", 8'h80, 8'hC0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
